// File: rtl/norz_int_pkg.sv
// Shared definitions for the interrupt-mode sequencer: mode encodings, FSM states,
// default restart vector and the mode-strobe priority helpers.
package norz_int_pkg;

    localparam logic [1:0]  IM_MODE0           = 2'b00;
    localparam logic [1:0]  IM_MODE1           = 2'b01;
    localparam logic [1:0]  IM_MODE2           = 2'b10;
    localparam logic [15:0] RST_VECTOR_DEFAULT = 16'h0038;

    typedef enum logic [2:0] {
        IDLE,
        ACK,
        INJECT,
        PUSH,
        RD_LO,
        RD_HI,
        VECTOR
    } seq_state_t;

    typedef enum logic [1:0] {
        F_IDLE,
        F_LO,
        F_HI
    } fetch_state_t;

    // IM2 beats IM1 beats IM0 when the decoder raises several strobes together.
    function automatic logic [1:0] im_select(input logic [1:0] cur, input logic s0,
                                             input logic s1, input logic s2);
        logic [1:0] res;
        res = cur;
        if (s2)      res = IM_MODE2;
        else if (s1) res = IM_MODE1;
        else if (s0) res = IM_MODE0;
        return res;
    endfunction

    // The unused encoding 11 behaves as IM0.
    function automatic logic [1:0] im_effective(input logic [1:0] m);
        return (m == IM_MODE1 || m == IM_MODE2) ? m : IM_MODE0;
    endfunction

endpackage

// File: rtl/int_vector_fetch.sv
// IM2 table fetch: reads the low then high vector byte from {I,vector byte} and
// {I,vector byte}+1, and hands the assembled 16-bit vector back to the parent FSM.
module int_vector_fetch
    import norz_int_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] base_addr,
    input  logic        read_done,
    input  logic [7:0]  data,
    output logic        read_req,
    output logic [15:0] read_addr,
    output logic        hi_phase,
    output logic        done,
    output logic [15:0] vector
);

    fetch_state_t state_q, state_d;
    logic [15:0]  base_q;
    logic [7:0]   lo_q, hi_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= F_IDLE;
            base_q  <= 16'h0000;
            lo_q    <= 8'h00;
            hi_q    <= 8'h00;
        end else begin
            state_q <= state_d;
            if (state_q == F_IDLE && start) base_q <= base_addr;
            if (state_q == F_LO && read_done) lo_q <= data;
            if (state_q == F_HI && read_done) hi_q <= data;
        end
    end

    always_comb begin
        state_d   = state_q;
        read_req  = 1'b0;
        read_addr = 16'h0000;
        hi_phase  = 1'b0;
        done      = 1'b0;
        case (state_q)
            F_IDLE: if (start) state_d = F_LO;
            F_LO: begin
                read_req  = 1'b1;
                read_addr = base_q;
                if (read_done) state_d = F_HI;
            end
            F_HI: begin
                read_req  = 1'b1;
                // Natural 16-bit wrap: FFFF is followed by 0000.
                read_addr = base_q + 16'd1;
                hi_phase  = 1'b1;
                if (read_done) begin
                    done    = 1'b1;
                    state_d = F_IDLE;
                end
            end
            default: state_d = F_IDLE;
        endcase
    end

    assign vector = {hi_q, lo_q};

endmodule

// File: rtl/interrupt_mode_sequencer.sv
// Holds the IM register and runs the maskable-interrupt acknowledge sequence
// (IM0 opcode injection, IM1 restart vector, IM2 push plus table fetch).
module interrupt_mode_sequencer
    import norz_int_pkg::*;
#(
    parameter logic [15:0] RST_VECTOR = RST_VECTOR_DEFAULT,
    parameter int          ACK_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        P2_IM0,
    input  logic        P2_IM1,
    input  logic        P2_IM2,
    input  logic        IntReq,
    input  logic        IFF1,
    input  logic        InstrEnd,
    input  logic [7:0]  I_Reg,
    input  logic [7:0]  DataBus,
    input  logic        PushDone,
    input  logic        ReadDone,
    output logic [1:0]  IM,
    output logic        Busy,
    output logic        IntAck,
    output logic        ClearIFF,
    output logic        PushReq,
    output logic        ReadReq,
    output logic [15:0] ReadAddr,
    output logic        InjectValid,
    output logic [7:0]  InjectOp,
    output logic        VectorValid,
    output logic [15:0] VectorAddr,
    output seq_state_t  fsm_state
);

    localparam int            CW       = (ACK_CYCLES > 1) ? $clog2(ACK_CYCLES) : 1;
    localparam logic [CW-1:0] ACK_LAST = CW'(ACK_CYCLES - 1);

    seq_state_t    state_q, state_d;
    logic [1:0]    im_q, mode_q;
    logic [CW-1:0] cnt_q;
    logic [7:0]    vec_q;
    logic          accept, ack_last;
    logic          fetch_start, fetch_done, fetch_hi;
    logic [15:0]   fetch_vector;

    assign accept   = !reset && state_q == IDLE && InstrEnd && IntReq && IFF1;
    assign ack_last = (cnt_q == ACK_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            im_q    <= IM_MODE0;
            mode_q  <= IM_MODE0;
            cnt_q   <= '0;
            vec_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            im_q    <= im_select(im_q, P2_IM0, P2_IM1, P2_IM2);
            // The mode in force before this edge's strobe update owns the sequence.
            if (accept) mode_q <= im_effective(im_q);
            cnt_q <= (state_q == ACK) ? cnt_q + 1'b1 : '0;
            if (state_q == ACK && ack_last) vec_q <= DataBus;
        end
    end

    always_comb begin
        state_d     = state_q;
        ClearIFF    = 1'b0;
        IntAck      = 1'b0;
        PushReq     = 1'b0;
        InjectValid = 1'b0;
        InjectOp    = 8'h00;
        VectorValid = 1'b0;
        VectorAddr  = 16'h0000;
        fetch_start = 1'b0;
        case (state_q)
            IDLE: if (accept) begin
                ClearIFF = 1'b1;
                state_d  = ACK;
            end
            ACK: begin
                IntAck = 1'b1;
                if (ack_last) state_d = (mode_q == IM_MODE0) ? INJECT : PUSH;
            end
            INJECT: begin
                InjectValid = 1'b1;
                InjectOp    = vec_q;
                state_d     = IDLE;
            end
            PUSH: begin
                PushReq = 1'b1;
                if (PushDone) begin
                    if (mode_q == IM_MODE2) begin
                        fetch_start = 1'b1;
                        state_d     = RD_LO;
                    end else begin
                        state_d = VECTOR;
                    end
                end
            end
            // Both table reads live in the fetch unit; the parent just waits for done.
            RD_LO: if (fetch_done) state_d = VECTOR;
            VECTOR: begin
                VectorValid = 1'b1;
                VectorAddr  = (mode_q == IM_MODE1) ? RST_VECTOR : fetch_vector;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    int_vector_fetch u_fetch (
        .clk       (clk),
        .reset     (reset),
        .start     (fetch_start),
        .base_addr ({I_Reg, vec_q}),
        .read_done (ReadDone),
        .data      (DataBus),
        .read_req  (ReadReq),
        .read_addr (ReadAddr),
        .hi_phase  (fetch_hi),
        .done      (fetch_done),
        .vector    (fetch_vector)
    );

    assign IM        = im_q;
    assign Busy      = (state_q != IDLE);
    assign fsm_state = (state_q == RD_LO && fetch_hi) ? RD_HI : state_q;

endmodule

// File: tb/tb_interrupt_mode_sequencer.sv
// Randomised self-checking bench: a per-cycle expected timeline is built from the
// acknowledge rules for each interrupt and compared with the DUT outputs.
module tb_interrupt_mode_sequencer;
    import norz_int_pkg::*;

    localparam int ACK_N = 2;

    logic        clk = 1'b0;
    logic        reset, P2_IM0, P2_IM1, P2_IM2, IntReq, IFF1, InstrEnd, PushDone, ReadDone;
    logic [7:0]  I_Reg, DataBus;
    logic [1:0]  IM;
    logic        Busy, IntAck, ClearIFF, PushReq, ReadReq, InjectValid, VectorValid;
    logic [15:0] ReadAddr, VectorAddr;
    logic [7:0]  InjectOp;
    seq_state_t  fsm_state;

    typedef struct packed {
        logic        clear_iff;
        logic        int_ack;
        logic        push_req;
        logic        read_req;
        logic [15:0] read_addr;
        logic        inject_valid;
        logic [7:0]  inject_op;
        logic        vector_valid;
        logic [15:0] vector_addr;
        logic        busy;
    } obs_t;
    localparam int OBS_W = $bits(obs_t);

    logic [OBS_W-1:0] exp_q[$];
    logic             push_q[$];
    logic             rdone_q[$];
    logic [7:0]       db_q[$];
    logic [7:0]       ir_q[$];
    logic [1:0]       im_model;
    int               checks = 0;
    int               errors = 0;

    always #5 clk = ~clk;

    interrupt_mode_sequencer #(.RST_VECTOR(16'h0038), .ACK_CYCLES(ACK_N)) dut (
        .clk(clk), .reset(reset), .P2_IM0(P2_IM0), .P2_IM1(P2_IM1), .P2_IM2(P2_IM2),
        .IntReq(IntReq), .IFF1(IFF1), .InstrEnd(InstrEnd), .I_Reg(I_Reg), .DataBus(DataBus),
        .PushDone(PushDone), .ReadDone(ReadDone), .IM(IM), .Busy(Busy), .IntAck(IntAck),
        .ClearIFF(ClearIFF), .PushReq(PushReq), .ReadReq(ReadReq), .ReadAddr(ReadAddr),
        .InjectValid(InjectValid), .InjectOp(InjectOp), .VectorValid(VectorValid),
        .VectorAddr(VectorAddr), .fsm_state(fsm_state)
    );

    function automatic logic [7:0] rnd8();
        return 8'($urandom_range(0, 255));
    endfunction

    function automatic logic [1:0] im_rule(input logic [1:0] cur, input logic s0, input logic s1,
                                           input logic s2);
        if (s2) return 2'b10;
        if (s1) return 2'b01;
        if (s0) return 2'b00;
        return cur;
    endfunction

    function automatic obs_t observe();
        obs_t o;
        o.clear_iff    = ClearIFF;
        o.int_ack      = IntAck;
        o.push_req     = PushReq;
        o.read_req     = ReadReq;
        o.read_addr    = ReadAddr;
        o.inject_valid = InjectValid;
        o.inject_op    = InjectOp;
        o.vector_valid = VectorValid;
        o.vector_addr  = VectorAddr;
        o.busy         = Busy;
        return o;
    endfunction

    function automatic void add_cycle(input obs_t e, input logic pdn, input logic rdn,
                                      input logic [7:0] db, input logic [7:0] ir);
        exp_q.push_back(e);
        push_q.push_back(pdn);
        rdone_q.push_back(rdn);
        db_q.push_back(db);
        ir_q.push_back(ir);
    endfunction

    task automatic quiet();
        reset = 1'b0; P2_IM0 = 1'b0; P2_IM1 = 1'b0; P2_IM2 = 1'b0;
        IntReq = 1'b0; IFF1 = 1'b0; InstrEnd = 1'b0; PushDone = 1'b0; ReadDone = 1'b0;
        I_Reg = 8'h00; DataBus = 8'h00;
    endtask

    task automatic tick();
        logic [1:0] nxt;
        nxt = reset ? 2'b00 : im_rule(im_model, P2_IM0, P2_IM1, P2_IM2);
        @(posedge clk);
        im_model = nxt;
    endtask

    task automatic set_mode(input int m);
        @(negedge clk);
        quiet();
        case (m)
            0: P2_IM0 = 1'b1;
            1: P2_IM1 = 1'b1;
            default: P2_IM2 = 1'b1;
        endcase
        tick();
    endtask

    // One accepted interrupt: build the expected timeline, then play it cycle by cycle.
    task automatic run_sequence(input string tag, input logic [7:0] ireg, input logic [7:0] dbyte,
                                input logic [7:0] lo_b, input logic [7:0] hi_b, input int pd,
                                input int r0, input int r1, input logic [2:0] acc_strobe,
                                input bit rand_ignored, input bit abort_hi, input bit no_tail);
        obs_t        e, o;
        logic [1:0]  mode;
        logic [15:0] a_lo, a_hi, vec;
        int          abort_at;
        exp_q.delete(); push_q.delete(); rdone_q.delete(); db_q.delete(); ir_q.delete();
        mode     = im_model;
        abort_at = -1;
        e = '0; e.clear_iff = 1'b1;
        add_cycle(e, 1'b0, 1'b0, rnd8(), ireg);
        for (int i = 1; i <= ACK_N; i++) begin
            e = '0; e.int_ack = 1'b1; e.busy = 1'b1;
            add_cycle(e, 1'b0, 1'b0, (i == ACK_N) ? dbyte : rnd8(), ireg);
        end
        if (mode == 2'b01 || mode == 2'b10) begin
            for (int i = 0; i <= pd; i++) begin
                e = '0; e.push_req = 1'b1; e.busy = 1'b1;
                add_cycle(e, i == pd, 1'b0, rnd8(), ireg);
            end
            if (mode == 2'b01) begin
                vec = 16'h0038;
            end else begin
                a_lo = {ireg, dbyte};
                a_hi = a_lo + 16'd1;
                for (int i = 0; i <= r0; i++) begin
                    e = '0; e.read_req = 1'b1; e.read_addr = a_lo; e.busy = 1'b1;
                    add_cycle(e, 1'b0, i == r0, (i == r0) ? lo_b : rnd8(), rnd8());
                end
                if (abort_hi) abort_at = exp_q.size() + 1;
                for (int i = 0; i <= r1; i++) begin
                    e = '0; e.read_req = 1'b1; e.read_addr = a_hi; e.busy = 1'b1;
                    add_cycle(e, 1'b0, i == r1, (i == r1) ? hi_b : rnd8(), rnd8());
                end
                vec = {hi_b, lo_b};
            end
            e = '0; e.vector_valid = 1'b1; e.vector_addr = vec; e.busy = 1'b1;
            add_cycle(e, 1'b0, 1'b0, rnd8(), rnd8());
        end else begin
            e = '0; e.inject_valid = 1'b1; e.inject_op = dbyte; e.busy = 1'b1;
            add_cycle(e, 1'b0, 1'b0, rnd8(), rnd8());
        end
        if (!no_tail) begin
            e = '0;
            add_cycle(e, 1'b0, 1'b0, rnd8(), ireg);
        end

        for (int c = 0; c < exp_q.size(); c++) begin
            bit tail;
            tail = !no_tail && (c == exp_q.size() - 1);
            @(negedge clk);
            if (c == 0) begin
                {InstrEnd, IntReq, IFF1} = 3'b111;
                {P2_IM2, P2_IM1, P2_IM0} = acc_strobe;
            end else if (rand_ignored && !tail) begin
                {InstrEnd, IntReq, IFF1} = 3'($urandom_range(0, 7));
                {P2_IM2, P2_IM1, P2_IM0} = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
            end else begin
                {InstrEnd, IntReq, IFF1} = 3'b000;
                {P2_IM2, P2_IM1, P2_IM0} = 3'b000;
            end
            PushDone = push_q[c];
            ReadDone = rdone_q[c];
            DataBus  = db_q[c];
            I_Reg    = ir_q[c];
            reset    = (c == abort_at);
            #2;
            o = observe();
            checks++;
            if (o !== obs_t'(exp_q[c])) begin
                errors++;
                $display("FAIL %s cycle %0d outputs: got %h expected %h", tag, c, o, exp_q[c]);
            end
            checks++;
            if (IM !== im_model) begin
                errors++;
                $display("FAIL %s cycle %0d IM: got %b expected %b", tag, c, IM, im_model);
            end
            tick();
            if (c == abort_at) break;
        end

        if (abort_at >= 0) begin
            @(negedge clk);
            quiet();
            #2;
            o = observe();
            checks++;
            if (o !== obs_t'('0) || IM !== 2'b00) begin
                errors++;
                $display("FAIL %s after_reset: got %h IM %b expected all zero", tag, o, IM);
            end
            tick();
        end
    endtask

    task automatic test_reset();
        obs_t o;
        quiet();
        reset = 1'b1; IntReq = 1'b1; IFF1 = 1'b1; InstrEnd = 1'b1; P2_IM2 = 1'b1;
        tick();
        tick();
        @(negedge clk);
        #2;
        o = observe();
        checks++;
        if (o !== obs_t'('0) || IM !== 2'b00) begin
            errors++;
            $display("FAIL reset_hold: got %h IM %b expected all zero", o, IM);
        end
        checks++;
        if (fsm_state !== IDLE) begin
            errors++;
            $display("FAIL reset_state: got %0d expected IDLE", fsm_state);
        end
        tick();
        @(negedge clk);
        quiet();
        #2;
        o = observe();
        checks++;
        if (o !== obs_t'('0) || IM !== 2'b00) begin
            errors++;
            $display("FAIL reset_release: got %h IM %b expected all zero", o, IM);
        end
        tick();
    endtask

    task automatic test_im_strobes();
        set_mode(2);
        @(negedge clk); quiet(); #2;
        checks++;
        if (IM !== 2'b10) begin errors++; $display("FAIL im2_strobe: got %b expected 10", IM); end
        tick();
        set_mode(0);
        @(negedge clk); quiet(); P2_IM1 = 1'b1; P2_IM2 = 1'b1; #2;
        checks++;
        if (IM !== 2'b00) begin errors++; $display("FAIL im0_strobe: got %b expected 00", IM); end
        tick();
        @(negedge clk); quiet(); #2;
        checks++;
        if (IM !== 2'b10) begin errors++; $display("FAIL im1_im2_strobe: got %b expected 10", IM); end
        tick();
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            quiet();
            {P2_IM2, P2_IM1, P2_IM0} = 3'($urandom_range(0, 7));
            #2;
            checks++;
            if (IM !== im_model) begin
                errors++;
                $display("FAIL im_random %0d: got %b expected %b", i, IM, im_model);
            end
            tick();
        end
    endtask

    task automatic test_im0();
        set_mode(0);
        run_sequence("im0_ff", rnd8(), 8'hFF, 8'h00, 8'h00, 0, 0, 0, 3'b000, 0, 0, 0);
        run_sequence("im0_rand", rnd8(), rnd8(), 8'h00, 8'h00, 0, 0, 0, 3'b000, 1, 0, 0);
    endtask

    task automatic test_im1();
        set_mode(1);
        run_sequence("im1_push3", rnd8(), rnd8(), 8'h00, 8'h00, 3, 0, 0, 3'b000, 0, 0, 0);
        run_sequence("im1_push0", rnd8(), rnd8(), 8'h00, 8'h00, 0, 0, 0, 3'b000, 1, 0, 0);
    endtask

    task automatic test_im2();
        set_mode(2);
        run_sequence("im2_abcd", 8'h12, 8'h34, 8'hCD, 8'hAB, 1, 1, 0, 3'b000, 0, 0, 0);
        run_sequence("im2_wrap", 8'hFF, 8'hFF, rnd8(), rnd8(), 0, 0, 0, 3'b000, 0, 0, 0);
        run_sequence("im2_slow", rnd8(), rnd8(), rnd8(), rnd8(), 2, 3, 2, 3'b000, 1, 0, 0);
    endtask

    task automatic test_mode_switch();
        set_mode(2);
        run_sequence("im2_then_im1", 8'h56, 8'h78, rnd8(), rnd8(), 1, 0, 1, 3'b010, 0, 0, 0);
        @(negedge clk); quiet(); #2;
        checks++;
        if (IM !== 2'b01) begin errors++; $display("FAIL mode_after_switch: got %b expected 01", IM); end
        tick();
    endtask

    task automatic test_no_accept();
        obs_t o;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            quiet();
            InstrEnd = (i % 3) != 0;
            IFF1     = (i % 3) != 1;
            IntReq   = (i % 3) != 2;
            DataBus  = rnd8();
            #2;
            o = observe();
            checks++;
            if (o !== obs_t'('0)) begin
                errors++;
                $display("FAIL no_accept %0d: got %h expected all zero", i, o);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        set_mode(1);
        run_sequence("b2b_first", rnd8(), rnd8(), 8'h00, 8'h00, 1, 0, 0, 3'b001, 0, 0, 1);
        run_sequence("b2b_second", rnd8(), 8'h3C, 8'h00, 8'h00, 0, 0, 0, 3'b100, 0, 0, 1);
        run_sequence("b2b_third", 8'h80, 8'h10, 8'h22, 8'h11, 0, 1, 0, 3'b000, 0, 0, 0);
    endtask

    task automatic test_reset_mid();
        set_mode(2);
        run_sequence("reset_rd_hi", 8'h40, 8'h20, 8'h99, 8'h88, 0, 0, 4, 3'b000, 0, 1, 0);
        run_sequence("after_abort", rnd8(), 8'hC7, 8'h00, 8'h00, 0, 0, 0, 3'b000, 0, 0, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 12; i++) begin
            set_mode($urandom_range(0, 2));
            run_sequence("random", rnd8(), rnd8(), rnd8(), rnd8(), $urandom_range(0, 3),
                         $urandom_range(0, 3), $urandom_range(0, 3),
                         3'($urandom_range(0, 7)), 1, 0, (i % 3) == 0);
        end
    endtask

    initial begin
        im_model = 2'b00;
        quiet();
        reset = 1'b1;
        test_reset();
        test_im_strobes();
        test_im0();
        test_im1();
        test_im2();
        test_mode_switch();
        test_no_accept();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
